// File: rtl/namuru_dump_fifo.sv
// namuru_dump_fifo: record FIFO capturing channel-0 correlator accumulation
// dumps for word-by-word CPU readout in the sys_clk domain.
// Optional feature macro: NAMURU_DUMP_TIMESTAMP_EN adds a fifth word per
// record holding a free-running sys_clk cycle count sampled at dump_stb.
module namuru_dump_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned IRQ_LEVEL  = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  dump_stb,
    input  logic [15:0]           i_early,
    input  logic [15:0]           q_early,
    input  logic [15:0]           i_prompt,
    input  logic [15:0]           q_prompt,
    input  logic [15:0]           i_late,
    input  logic [15:0]           q_late,
    input  logic [10:0]           epoch,
    input  logic                  rd_stb,
    output logic [31:0]           rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  flush,
    output logic [7:0]            drop_count,
    output logic                  irq
);

`ifdef NAMURU_DUMP_TIMESTAMP_EN
    localparam int unsigned WPR = 5;
`else
    localparam int unsigned WPR = 4;
`endif
    localparam int unsigned CAP = 1 << DEPTH_LOG2;
    localparam int unsigned AW  = $clog2(CAP * WPR);

    typedef enum logic {IDLE, WR} wr_state_t;

    wr_state_t               state, state_next;
    logic [2:0]              widx;
    logic [2:0]              rd_widx;
    logic [DEPTH_LOG2-1:0]   wr_rec;
    logic [DEPTH_LOG2-1:0]   rd_rec;
    logic                    commit_q;
    logic [15:0]             seq;
    logic [31:0]             st_w0, st_w1, st_w2, st_w3;
    logic [31:0]             wr_word;
    logic [AW-1:0]           wr_addr, rd_addr;
    logic [DEPTH_LOG2+1:0]   occupancy;
    logic                    pending, full;
    logic                    accept, drop, wr_en, last_word;
    logic                    rd_fire, release_rec;
    logic [31:0]             ram [CAP*WPR];

`ifdef NAMURU_DUMP_TIMESTAMP_EN
    logic [31:0]             cycle_cnt;
    logic [31:0]             st_w4;

    // Free-running timestamp counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    // A record still being written or awaiting commit already owns a slot
    assign pending   = (state == WR) || commit_q;
    assign occupancy = {1'b0, level} + (DEPTH_LOG2+2)'(pending);
    assign full      = occupancy >= (DEPTH_LOG2+2)'(CAP);

    assign wr_addr = AW'(wr_rec) * AW'(WPR) + AW'(widx);
    assign rd_addr = AW'(rd_rec) * AW'(WPR) + AW'(rd_widx);

    assign rd_fire     = rd_stb && (level != '0) && !flush;
    assign release_rec = rd_fire && (rd_widx == 3'(WPR-1));

    // Write FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Write FSM next state, accept/drop decision and RAM write enable
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        wr_en      = 1'b0;
        last_word  = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_stb) begin
                        if (!full) begin
                            accept     = 1'b1;
                            state_next = WR;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                WR: begin
                    wr_en = 1'b1;
                    if (widx == 3'(WPR-1)) begin
                        last_word  = 1'b1;
                        state_next = IDLE;
                    end
                    if (dump_stb) drop = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Select the staged word for the current write index
    always_comb begin
        wr_word = '0;
        case (widx)
            3'd0:    wr_word = st_w0;
            3'd1:    wr_word = st_w1;
            3'd2:    wr_word = st_w2;
            3'd3:    wr_word = st_w3;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
            3'd4:    wr_word = st_w4;
`endif
            default: wr_word = '0;
        endcase
    end

    // Write-side counters: word index, record pointer, commit flag, sequence
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            widx     <= '0;
            wr_rec   <= '0;
            commit_q <= 1'b0;
            seq      <= '0;
        end else if (flush) begin
            widx     <= '0;
            wr_rec   <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= last_word;
            if (accept) begin
                widx <= '0;
                seq  <= seq + 16'd1;
            end else if (wr_en) begin
                widx <= last_word ? 3'd0 : widx + 3'd1;
            end
            if (last_word) wr_rec <= wr_rec + 1'b1;
        end
    end

    // Snapshot dump inputs into staging words on acceptance
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            st_w0 <= {i_early, q_early};
            st_w1 <= {i_prompt, q_prompt};
            st_w2 <= {i_late, q_late};
            st_w3 <= {seq, 5'b0, epoch};
`ifdef NAMURU_DUMP_TIMESTAMP_EN
            st_w4 <= cycle_cnt;
`endif
        end
    end

    // Record RAM write port
    always_ff @(posedge sys_clk) begin
        if (wr_en) ram[wr_addr] <= wr_word;
    end

    // Read data register: empty-FIFO reads return zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst)     rd_data <= '0;
        else if (rd_stb) rd_data <= rd_fire ? ram[rd_addr] : 32'h0;
    end

    // Read pointers: word index within record, record index
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            rd_widx <= '0;
            rd_rec  <= '0;
        end else if (rd_fire) begin
            if (release_rec) begin
                rd_widx <= '0;
                rd_rec  <= rd_rec + 1'b1;
            end else begin
                rd_widx <= rd_widx + 3'd1;
            end
        end
    end

    // Complete-record level: commit and release in one cycle cancel
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            level <= '0;
        end else begin
            case ({commit_q, release_rec})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a new drop beats ovf_clr
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)                 drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Registered fill-threshold interrupt
    always_ff @(posedge sys_clk) begin
        if (sys_rst) irq <= 1'b0;
        else         irq <= (level >= (DEPTH_LOG2+1)'(IRQ_LEVEL));
    end

endmodule
